// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned ADDR_W_DEF   = 5;
    localparam int unsigned RD_PORTS_DEF = 2;
    localparam int unsigned WR_PORTS_DEF = 2;
    localparam int unsigned ZERO_REG     = 0;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one pending bit per register plus a registered population count.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned WR_PORTS = WR_PORTS_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WR_PORTS-1:0]          wr_en,
    input  logic [WR_PORTS*ADDR_W-1:0]   wr_addr,
    input  logic                         issue_en,
    input  logic [ADDR_W-1:0]            issue_addr,
    output logic [(2**ADDR_W)-1:0]       pending,
    output logic [ADDR_W:0]              pend_cnt
);

    localparam int unsigned DEPTH = 2**ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;
    logic [DEPTH-1:0] set_c;
    logic [DEPTH-1:0] clr_c;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A new issue overrides a completing write to the same register.
    always_comb begin
        set_c = '0;
        clr_c = '0;
        for (int unsigned p = 0; p < WR_PORTS; p++) begin
            if (wr_en[p]) begin
                clr_c[wr_addr[p*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
        if (issue_en) begin
            set_c[issue_addr] = 1'b1;
        end
        set_c[ADDR_W'(ZERO_REG)] = 1'b0;
        pend_d = set_c | (pend_q & ~clr_c);
        cnt_d  = '0;
        for (int unsigned r = 0; r < DEPTH; r++) begin
            cnt_d = cnt_d + CNT_W'(pend_d[r]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pending  = pend_q;
    assign pend_cnt = cnt_q;

endmodule

// File: rtl/regfile_multiport.sv
// Multi-port register file with hardwired-zero x0 and pending-write scoreboard.
// Optional same-cycle write-to-read bypass when REGFILE_BYPASS_EN is defined.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned RD_PORTS = RD_PORTS_DEF,
    parameter int unsigned WR_PORTS = WR_PORTS_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
    output logic [RD_PORTS*DATA_W-1:0]   rd_data,
    output logic [RD_PORTS-1:0]          rd_busy,
    input  logic [WR_PORTS-1:0]          wr_en,
    input  logic [WR_PORTS*ADDR_W-1:0]   wr_addr,
    input  logic [WR_PORTS*DATA_W-1:0]   wr_data,
    input  logic                         issue_en,
    input  logic [ADDR_W-1:0]            issue_addr,
    output logic [ADDR_W:0]              pend_cnt
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rdat;
    logic              rbusy;

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .WR_PORTS (WR_PORTS)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .pending    (pending),
        .pend_cnt   (pend_cnt)
    );

    // Ascending port order: the last assignment (highest port) wins on a conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            for (int unsigned p = 0; p < WR_PORTS; p++) begin
                if (wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] != ADDR_W'(ZERO_REG))) begin
                    mem_q[wr_addr[p*ADDR_W +: ADDR_W]] <= wr_data[p*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        rdat    = '0;
        rbusy   = 1'b0;
        for (int unsigned i = 0; i < RD_PORTS; i++) begin
            ra    = rd_addr[i*ADDR_W +: ADDR_W];
            rdat  = (ra == ADDR_W'(ZERO_REG)) ? '0 : mem_q[ra];
            rbusy = pending[ra];
`ifdef REGFILE_BYPASS_EN
            // Forward in-flight write data; the register is busy only if re-issued this cycle.
            for (int unsigned p = 0; p < WR_PORTS; p++) begin
                if (wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] == ra) &&
                    (ra != ADDR_W'(ZERO_REG))) begin
                    rdat  = wr_data[p*DATA_W +: DATA_W];
                    rbusy = issue_en && (issue_addr == ra);
                end
            end
`endif
            rd_data[i*DATA_W +: DATA_W] = rdat;
            rd_busy[i]                  = rbusy;
        end
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench for regfile_multiport: directed scenarios plus a randomised burst vs a reference model.
module tb_regfile_multiport;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int RDP = 2;
    localparam int WRP = 2;
    localparam int NREG = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [RDP*AW-1:0] rd_addr;
    logic [RDP*DW-1:0] rd_data;
    logic [RDP-1:0]    rd_busy;
    logic [WRP-1:0]    wr_en;
    logic [WRP*AW-1:0] wr_addr;
    logic [WRP*DW-1:0] wr_data;
    logic              issue_en;
    logic [AW-1:0]     issue_addr;
    logic [AW:0]       pend_cnt;

    logic [DW-1:0] m_mem  [NREG];
    bit            m_pend [NREG];
    int checks = 0;
    int errors = 0;

    regfile_multiport #(
        .DATA_W(DW), .ADDR_W(AW), .RD_PORTS(RDP), .WR_PORTS(WRP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr), .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int m_cnt();
        int n = 0;
        for (int r = 0; r < NREG; r++) n += int'(m_pend[r]);
        return n;
    endfunction

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        if (a == 0) return '0;
        v = m_mem[a];
`ifdef REGFILE_BYPASS_EN
        for (int p = 0; p < WRP; p++)
            if (wr_en[p] && wr_addr[p*AW +: AW] == a) v = wr_data[p*DW +: DW];
`endif
        return v;
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        logic b;
        b = m_pend[a];
`ifdef REGFILE_BYPASS_EN
        for (int p = 0; p < WRP; p++)
            if (a != 0 && wr_en[p] && wr_addr[p*AW +: AW] == a)
                b = issue_en && (issue_addr == a);
`endif
        return b;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < NREG; r++) begin
            m_mem[r]  = '0;
            m_pend[r] = 1'b0;
        end
    endtask

    // Apply the architectural effect of the current inputs at a clock edge.
    task automatic model_update();
        bit clr [NREG];
        for (int r = 0; r < NREG; r++) clr[r] = 1'b0;
        for (int p = 0; p < WRP; p++) begin
            if (wr_en[p]) begin
                clr[wr_addr[p*AW +: AW]] = 1'b1;
                if (wr_addr[p*AW +: AW] != 0) m_mem[wr_addr[p*AW +: AW]] = wr_data[p*DW +: DW];
            end
        end
        for (int r = 1; r < NREG; r++) begin
            if (issue_en && issue_addr == AW'(r)) m_pend[r] = 1'b1;
            else if (clr[r])                      m_pend[r] = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_update();
        else       model_clear();
        @(negedge clk);
    endtask

    task automatic idle();
        wr_en      = '0;
        wr_addr    = '0;
        wr_data    = '0;
        issue_en   = 1'b0;
        issue_addr = '0;
    endtask

    task automatic test_reset();
        rd_addr = {AW'(31), AW'(5)};
        #1;
        checks++;
        if (rd_data !== '0 || rd_busy !== '0 || pend_cnt !== '0) begin
            errors++;
            $display("FAIL reset_state: data=%h busy=%b cnt=%0d required 0/0/0", rd_data, rd_busy, pend_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wr_en = 2'b01; wr_addr = {AW'(0), AW'(5)}; wr_data = {32'h0, 32'hDEADBEEF};
        issue_en = 1'b1; issue_addr = AW'(6);
        rd_addr = {AW'(6), AW'(5)};
        tick();
        idle();
        #1;
        checks++;
        if (rd_data[31:0] !== 32'hDEADBEEF || rd_busy[1] !== 1'b1 || pend_cnt !== 6'd1) begin
            errors++;
            $display("FAIL pre_reset_write: x5=%h busy6=%b cnt=%0d required deadbeef/1/1",
                     rd_data[31:0], rd_busy[1], pend_cnt);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h0 || rd_busy !== 2'b00 || pend_cnt !== 6'd0) begin
            errors++;
            $display("FAIL async_reset: x5=%h busy=%b cnt=%0d required 0/00/0", rd_data[31:0], rd_busy, pend_cnt);
        end
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_x0();
        wr_en = 2'b01; wr_addr = {AW'(0), AW'(0)}; wr_data = {32'h0, 32'h1234};
        issue_en = 1'b1; issue_addr = AW'(0);
        rd_addr = {AW'(0), AW'(0)};
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h0 || rd_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL x0_same_cycle: data=%h busy=%b required 0/0", rd_data[31:0], rd_busy[0]);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h0 || rd_busy[0] !== 1'b0 || pend_cnt !== 6'd0) begin
            errors++;
            $display("FAIL x0_after: data=%h busy=%b cnt=%0d required 0/0/0", rd_data[31:0], rd_busy[0], pend_cnt);
        end
    endtask

    task automatic test_write_conflict();
        wr_en = 2'b11; wr_addr = {AW'(7), AW'(7)}; wr_data = {32'h5555, 32'hAAAA};
        rd_addr = {AW'(0), AW'(7)};
        tick();
        idle();
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h5555) begin
            errors++;
            $display("FAIL write_conflict: x7=%h required 00005555", rd_data[31:0]);
        end
    endtask

    task automatic test_scoreboard();
        issue_en = 1'b1; issue_addr = AW'(3);
        tick();
        issue_addr = AW'(4);
        tick();
        idle();
        rd_addr = {AW'(4), AW'(3)};
        #1;
        checks++;
        if (pend_cnt !== 6'd2 || rd_busy !== 2'b11) begin
            errors++;
            $display("FAIL sb_two_issued: cnt=%0d busy=%b required 2/11", pend_cnt, rd_busy);
        end
        wr_en = 2'b11; wr_addr = {AW'(4), AW'(3)}; wr_data = {32'h44, 32'h33};
        tick();
        idle();
        #1;
        checks++;
        if (pend_cnt !== 6'd0 || rd_busy !== 2'b00 || rd_data !== {32'h44, 32'h33}) begin
            errors++;
            $display("FAIL sb_dual_clear: cnt=%0d busy=%b data=%h required 0/00/0000004400000033",
                     pend_cnt, rd_busy, rd_data);
        end
        issue_en = 1'b1; issue_addr = AW'(9);
        wr_en = 2'b01; wr_addr = {AW'(0), AW'(9)}; wr_data = {32'h0, 32'h99};
        tick();
        idle();
        rd_addr = {AW'(0), AW'(9)};
        #1;
        checks++;
        if (rd_busy[0] !== 1'b1 || pend_cnt !== 6'd1) begin
            errors++;
            $display("FAIL sb_set_wins: busy=%b cnt=%0d required 1/1", rd_busy[0], pend_cnt);
        end
        issue_en = 1'b1; issue_addr = AW'(9);
        tick();
        idle();
        #1;
        checks++;
        if (rd_busy[0] !== 1'b1 || pend_cnt !== 6'd1) begin
            errors++;
            $display("FAIL sb_reissue: busy=%b cnt=%0d required 1/1", rd_busy[0], pend_cnt);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] want_same;
        logic        want_busy;
`ifdef REGFILE_BYPASS_EN
        want_same = 32'hCAFE;
        want_busy = 1'b0;
`else
        want_same = 32'h1111;
        want_busy = 1'b1;
`endif
        wr_en = 2'b01; wr_addr = {AW'(0), AW'(10)}; wr_data = {32'h0, 32'h1111};
        issue_en = 1'b1; issue_addr = AW'(11);
        tick();
        idle();
        wr_en = 2'b11; wr_addr = {AW'(11), AW'(10)}; wr_data = {32'hB11, 32'hCAFE};
        rd_addr = {AW'(11), AW'(10)};
        #1;
        checks++;
        if (rd_data[31:0] !== want_same || rd_busy[1] !== want_busy) begin
            errors++;
            $display("FAIL bypass_same_cycle: x10=%h busy11=%b required %h/%b",
                     rd_data[31:0], rd_busy[1], want_same, want_busy);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rd_data !== {32'hB11, 32'hCAFE} || rd_busy !== 2'b00) begin
            errors++;
            $display("FAIL bypass_after_edge: data=%h busy=%b required 00000b110000cafe/00", rd_data, rd_busy);
        end
    endtask

    function automatic logic [AW-1:0] rand_addr();
        return ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
    endfunction

    task automatic test_random();
        int n_err_start;
        n_err_start = errors;
        for (int c = 0; c < 1000; c++) begin
            for (int i = 0; i < RDP; i++) rd_addr[i*AW +: AW] = rand_addr();
            for (int p = 0; p < WRP; p++) begin
                wr_en[p]            = ($urandom_range(0, 2) == 0);
                wr_addr[p*AW +: AW] = rand_addr();
                wr_data[p*DW +: DW] = $urandom;
            end
            issue_en   = ($urandom_range(0, 2) != 0);
            issue_addr = rand_addr();
            #1;
            for (int i = 0; i < RDP; i++) begin
                checks++;
                if (rd_data[i*DW +: DW] !== exp_data(rd_addr[i*AW +: AW]) ||
                    rd_busy[i] !== exp_busy(rd_addr[i*AW +: AW])) begin
                    errors++;
                    $display("FAIL random_read cyc=%0d port=%0d addr=%0d: data=%h busy=%b required %h/%b",
                             c, i, rd_addr[i*AW +: AW], rd_data[i*DW +: DW], rd_busy[i],
                             exp_data(rd_addr[i*AW +: AW]), exp_busy(rd_addr[i*AW +: AW]));
                end
            end
            checks++;
            if (pend_cnt !== (AW+1)'(m_cnt())) begin
                errors++;
                $display("FAIL random_pend_cnt cyc=%0d: cnt=%0d required %0d", c, pend_cnt, m_cnt());
            end
            tick();
        end
        idle();
        if (errors != n_err_start)
            $display("random burst: %0d discrepancies", errors - n_err_start);
    endtask

    initial begin
        rst_n   = 1'b0;
        rd_addr = '0;
        idle();
        model_clear();
        @(negedge clk);
        test_reset();
        test_x0();
        test_write_conflict();
        test_scoreboard();
        test_bypass();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
